// File: rtl/ps2_mouse_device_sm.sv
// PS/2 mouse device-side protocol FSM: answers host commands with ACK/RESEND/BAT/ID bytes
// and, while streaming, emits 3-byte movement packets built from saturating accumulators.
module ps2_mouse_device_sm #(
    parameter int SAMPLE_PERIOD = 500000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] CMD_BYTE,
    input  logic       CMD_READY,
    input  logic       CMD_ERROR,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    input  logic       MOVE_VALID,
    input  logic [8:0] MOVE_DX,
    input  logic [8:0] MOVE_DY,
    input  logic [2:0] BUTTONS,
    output logic       STREAMING,
    output logic [3:0] DBG_STATE
);
    localparam int TW = $clog2(SAMPLE_PERIOD);

    typedef enum logic [3:0] {
        S_BAT_AA = 4'd0, S_BAT_ID = 4'd1, S_IDLE = 4'd2, S_ACK  = 4'd3,
        S_RESEND = 4'd4, S_PKT0   = 4'd5, S_PKT1 = 4'd6, S_PKT2 = 4'd7
    } state_t;

    state_t        state, state_nxt;
    logic          tx_wait, tx_wait_nxt;
    logic          take_cmd, take_pkt, send_now;
    logic [7:0]    tx_byte;

    logic          pend_valid, pend_err;
    logic [7:0]    pend_byte;
    logic          ack_reset;
    logic [TW-1:0] timer;
    logic [8:0]    acc_x, acc_y;
    logic          ov_x, ov_y;
    logic [2:0]    last_buttons;
    logic [7:0]    pkt_status, pkt_x, pkt_y;

    logic          idle_has_cmd, idle_is_err, new_cmd, expiry, report_due, clr_acc;
    logic [7:0]    idle_byte;
    logic [8:0]    base_x, base_y;
    logic [9:0]    add_x, add_y;

    // Returns {overflow, result}: sum clamped to the 9-bit signed range.
    function automatic logic [9:0] sat_add(input logic [8:0] a, input logic [8:0] b);
        logic [9:0] sum;
        sum = {a[8], a} + {b[8], b};
        if (sum[9] != sum[8])
            sat_add = {1'b1, (sum[9] ? 9'h100 : 9'h0FF)};
        else
            sat_add = {1'b0, sum[8:0]};
    endfunction

    // A live strobe in IDLE beats a stale pending entry (newest wins).
    assign new_cmd      = CMD_READY | CMD_ERROR;
    assign idle_has_cmd = new_cmd | pend_valid;
    assign idle_is_err  = CMD_ERROR | (!CMD_READY & pend_valid & pend_err);
    assign idle_byte    = CMD_READY ? CMD_BYTE : pend_byte;
    assign expiry       = STREAMING && (timer == TW'(SAMPLE_PERIOD - 1));
    assign report_due   = (acc_x != 9'd0) || (acc_y != 9'd0) || ov_x || ov_y ||
                          (BUTTONS != last_buttons);
    assign DBG_STATE    = state;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state   <= S_BAT_AA;
            tx_wait <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_wait <= tx_wait_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_wait_nxt = tx_wait;
        take_cmd    = 1'b0;
        take_pkt    = 1'b0;
        if (state == S_IDLE) begin
            tx_wait_nxt = 1'b0;
            if (idle_has_cmd) begin
                take_cmd  = 1'b1;
                state_nxt = idle_is_err ? S_RESEND : S_ACK;
            end else if (expiry && report_due) begin
                take_pkt  = 1'b1;
                state_nxt = S_PKT0;
            end
        end else if (!tx_wait) begin
            tx_wait_nxt = 1'b1;
        end else if (BYTE_SENT) begin
            tx_wait_nxt = 1'b0;
            case (state)
                S_BAT_AA: state_nxt = S_BAT_ID;
                S_ACK:    state_nxt = ack_reset ? S_BAT_AA : S_IDLE;
                S_PKT0:   state_nxt = (pend_valid || new_cmd) ? S_IDLE : S_PKT1;
                S_PKT1:   state_nxt = (pend_valid || new_cmd) ? S_IDLE : S_PKT2;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        send_now = (state != S_IDLE) && !tx_wait;
        case (state)
            S_BAT_AA: tx_byte = 8'hAA;
            S_ACK:    tx_byte = 8'hFA;
            S_RESEND: tx_byte = 8'hFE;
            S_PKT0:   tx_byte = pkt_status;
            S_PKT1:   tx_byte = pkt_x;
            S_PKT2:   tx_byte = pkt_y;
            default:  tx_byte = 8'h00;
        endcase
    end

    assign clr_acc = take_pkt ||
                     (take_cmd && !idle_is_err && (idle_byte == 8'hFF || idle_byte == 8'hF6));
    assign base_x  = clr_acc ? 9'd0 : acc_x;
    assign base_y  = clr_acc ? 9'd0 : acc_y;
    assign add_x   = sat_add(base_x, MOVE_DX);
    assign add_y   = sat_add(base_y, MOVE_DY);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            SEND_BYTE    <= 1'b0;
            BYTE_TO_SEND <= 8'h00;
            STREAMING    <= 1'b0;
            pend_valid   <= 1'b0;
            pend_err     <= 1'b0;
            pend_byte    <= 8'h00;
            ack_reset    <= 1'b0;
            timer        <= '0;
            acc_x        <= 9'd0;
            acc_y        <= 9'd0;
            ov_x         <= 1'b0;
            ov_y         <= 1'b0;
            last_buttons <= 3'b000;
            pkt_status   <= 8'h00;
            pkt_x        <= 8'h00;
            pkt_y        <= 8'h00;
        end else begin
            SEND_BYTE <= send_now;
            if (send_now)
                BYTE_TO_SEND <= tx_byte;

            if (state == S_IDLE) begin
                if (take_cmd)
                    pend_valid <= 1'b0;
            end else if (CMD_ERROR) begin
                pend_valid <= 1'b1;
                pend_err   <= 1'b1;
            end else if (CMD_READY) begin
                pend_valid <= 1'b1;
                pend_err   <= 1'b0;
                pend_byte  <= CMD_BYTE;
            end

            if (take_cmd) begin
                ack_reset <= !idle_is_err && (idle_byte == 8'hFF);
                if (!idle_is_err) begin
                    case (idle_byte)
                        8'hF4:                 STREAMING <= 1'b1;
                        8'hF5, 8'hF6, 8'hFF:   STREAMING <= 1'b0;
                        default:               STREAMING <= STREAMING;
                    endcase
                    if (idle_byte == 8'hFF || idle_byte == 8'hF6)
                        last_buttons <= 3'b000;
                end
            end

            if (!STREAMING || expiry)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (take_pkt) begin
                pkt_status   <= {ov_y, ov_x, acc_y[8], acc_x[8], 1'b1, BUTTONS};
                pkt_x        <= acc_x[7:0];
                pkt_y        <= acc_y[7:0];
                last_buttons <= BUTTONS;
            end

            // A move on a clearing cycle lands in the freshly cleared accumulators.
            if (MOVE_VALID) begin
                acc_x <= add_x[8:0];
                acc_y <= add_y[8:0];
                ov_x  <= (ov_x && !clr_acc) || add_x[9];
                ov_y  <= (ov_y && !clr_acc) || add_y[9];
            end else begin
                acc_x <= base_x;
                acc_y <= base_y;
                ov_x  <= ov_x && !clr_acc;
                ov_y  <= ov_y && !clr_acc;
            end
        end
    end
endmodule

// File: tb/tb_ps2_mouse_device_sm.sv
// Directed bench for the PS/2 mouse device FSM: plays host commands and transmitter
// completions, and checks the byte stream, handshake timing and streaming flag.
module tb_ps2_mouse_device_sm;
    localparam int P = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_ready = 1'b0;
    logic       cmd_error = 1'b0;
    logic       send_byte;
    logic [7:0] byte_to_send;
    logic       byte_sent = 1'b0;
    logic       move_valid = 1'b0;
    logic [8:0] move_dx = 9'd0;
    logic [8:0] move_dy = 9'd0;
    logic [2:0] buttons = 3'b000;
    logic       streaming;
    logic [3:0] dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ps2_mouse_device_sm #(.SAMPLE_PERIOD(P)) dut (
        .CLK(clk), .RESET(reset_n), .CMD_BYTE(cmd_byte), .CMD_READY(cmd_ready),
        .CMD_ERROR(cmd_error), .SEND_BYTE(send_byte), .BYTE_TO_SEND(byte_to_send),
        .BYTE_SENT(byte_sent), .MOVE_VALID(move_valid), .MOVE_DX(move_dx),
        .MOVE_DY(move_dy), .BUTTONS(buttons), .STREAMING(streaming), .DBG_STATE(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_byte();
        byte_sent = 1'b1;
        @(negedge clk);
        byte_sent = 1'b0;
    endtask

    task automatic cmd_pulse(input logic [7:0] b);
        cmd_byte  = b;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic err_pulse();
        cmd_error = 1'b1;
        @(negedge clk);
        cmd_error = 1'b0;
    endtask

    task automatic move(input logic [8:0] dx, input logic [8:0] dy);
        move_dx    = dx;
        move_dy    = dy;
        move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
    endtask

    // Waits (bounded) for a SEND_BYTE strobe, checks its byte and one-cycle width.
    task automatic wait_send(input string tag, input logic [7:0] exp, input bit ack);
        int k = 0;
        while (send_byte !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, " seen"}, 32'(k < 200), 32'd1);
        if (k < 200) begin
            check({tag, " byte"}, 32'(byte_to_send), 32'(exp));
            @(negedge clk);
            check({tag, " pulse"}, 32'(send_byte), 32'd0);
            if (ack) ack_byte();
        end
    endtask

    task automatic no_send(input string tag, input int n);
        int cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (send_byte === 1'b1) cnt++;
        end
        check(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        // 1: reset state, BAT sequence
        tick(3);
        check("rst send", 32'(send_byte), 32'd0);
        check("rst byte", 32'(byte_to_send), 32'h00);
        check("rst strm", 32'(streaming), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("bat first", 32'(send_byte), 32'd1);
        wait_send("bat aa", 8'hAA, 1'b1);
        wait_send("bat id", 8'h00, 1'b1);
        tick(2);
        check("bat strm", 32'(streaming), 32'd0);
        check("bat idle", 32'(dbg_state), 32'd2);

        // 2: enable streaming, one movement packet
        cmd_pulse(8'hF4);
        check("f4 strm", 32'(streaming), 32'd1);
        check("f4 lat0", 32'(send_byte), 32'd0);
        @(negedge clk);
        check("f4 lat", 32'(send_byte), 32'd1);
        wait_send("f4 ack", 8'hFA, 1'b1);
        buttons = 3'b001;
        move(9'd5, 9'h1FD);
        wait_send("p1 stat", 8'h29, 1'b1);
        wait_send("p1 dx", 8'h05, 1'b1);
        wait_send("p1 dy", 8'hFD, 1'b1);

        // 3: X saturation, then buttons-only report
        repeat (4) move(9'd100, 9'd0);
        wait_send("p2 stat", 8'h49, 1'b1);
        wait_send("p2 dx", 8'hFF, 1'b1);
        wait_send("p2 dy", 8'h00, 1'b1);
        buttons = 3'b000;
        wait_send("p3 stat", 8'h08, 1'b1);
        wait_send("p3 dx", 8'h00, 1'b1);
        wait_send("p3 dy", 8'h00, 1'b1);
        no_send("quiet", 100);

        // 4: resend request and unknown command
        err_pulse();
        wait_send("err fe", 8'hFE, 1'b1);
        check("err strm", 32'(streaming), 32'd1);
        cmd_pulse(8'h55);
        check("c55 lat0", 32'(send_byte), 32'd0);
        @(negedge clk);
        check("c55 lat", 32'(send_byte), 32'd1);
        wait_send("c55 ack", 8'hFA, 1'b1);
        check("c55 strm", 32'(streaming), 32'd1);

        // 5: disable arriving during PKT1 abandons PKT2
        move(9'd1, 9'd1);
        wait_send("p4 stat", 8'h08, 1'b1);
        wait_send("p4 dx", 8'h01, 1'b0);
        cmd_pulse(8'hF5);
        ack_byte();
        wait_send("f5 ack", 8'hFA, 1'b1);
        check("f5 strm", 32'(streaming), 32'd0);
        move(9'd3, 9'd3);
        no_send("f5 quiet", 100);

        // 6: reset command while streaming, then hardware reset mid-byte
        cmd_pulse(8'hF4);
        wait_send("f4b ack", 8'hFA, 1'b1);
        check("f4b strm", 32'(streaming), 32'd1);
        cmd_pulse(8'hFF);
        check("ff strm", 32'(streaming), 32'd0);
        wait_send("ff ack", 8'hFA, 1'b1);
        wait_send("ff aa", 8'hAA, 1'b1);
        wait_send("ff id", 8'h00, 1'b1);
        cmd_pulse(8'hF4);
        @(negedge clk);
        check("f4c send", 32'(send_byte), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid send", 32'(send_byte), 32'd0);
        check("mid byte", 32'(byte_to_send), 32'h00);
        check("mid strm", 32'(streaming), 32'd0);
        tick(2);
        reset_n = 1'b1;
        @(negedge clk);
        check("rbat first", 32'(send_byte), 32'd1);
        wait_send("rbat aa", 8'hAA, 1'b1);
        wait_send("rbat id", 8'h00, 1'b1);
        no_send("end quiet", 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
